// File: rtl/pulse_gen16_if.sv
// pulse_gen16_if: peripheral-bus bundle for the pulse generator.
// The master side drives the write strobes and control inputs. The slave
// side is the generator, which returns the status and pulse outputs.
// When PULSE_GEN16_PRESCALE_EN is defined, the bundle also carries the
// load_prescale strobe.
interface pulse_gen16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             load_period;
    logic             load_width;
    logic             start;
    logic             stop;
    logic             oneshot;
`ifdef PULSE_GEN16_PRESCALE_EN
    logic             load_prescale;
`endif
    logic [WIDTH-1:0] data_out;
    logic             pulse_out;
    logic             busy;
    logic             tick;

    modport master (
`ifdef PULSE_GEN16_PRESCALE_EN
        output load_prescale,
`endif
        output data_in, load_period, load_width, start, stop, oneshot,
        input  data_out, pulse_out, busy, tick
    );

    modport slave (
`ifdef PULSE_GEN16_PRESCALE_EN
        input  load_prescale,
`endif
        input  data_in, load_period, load_width, start, stop, oneshot,
        output data_out, pulse_out, busy, tick
    );
endinterface

// File: rtl/pulse_gen16.sv
// pulse_gen16: programmable periodic pulse generator.
// The generator supports continuous and one-shot modes.
// Period and width values are written into shadow registers. They are
// copied into the active registers on start and at each continuous wrap. A
// load in the same cycle bypasses its shadow register.
// Optional feature: define PULSE_GEN16_PRESCALE_EN to add an 8-bit prescaler
// (load_prescale strobe). The prescaler slows the phase counter by a factor
// of S+1.
module pulse_gen16 #(
    parameter int WIDTH = 16
) (
    input  logic          sysclk,
    input  logic          sysreset_n,
    pulse_gen16_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_sh_q, p_sh_d;
    logic [WIDTH-1:0] w_sh_q, w_sh_d;
    logic [WIDTH-1:0] p_act_q, p_act_d;
    logic [WIDTH-1:0] w_act_q, w_act_d;
    logic [WIDTH-1:0] ph_q, ph_d;
    logic             os_q, os_d;

    // Shadow values as seen this cycle: a write in progress wins.
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] w_next;
    logic             step;        // phase counter advances at this edge
    logic             period_end;  // last sysclk cycle of the period
    logic             reload;
    logic             halt;

`ifdef PULSE_GEN16_PRESCALE_EN
    logic [7:0] s_sh_q, s_sh_d;
    logic [7:0] s_act_q, s_act_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] s_next;
`endif

    // Bypassed shadow values, phase step enable and end-of-period detect.
    always_comb begin
        p_next = bus.load_period ? bus.data_in : p_sh_q;
        w_next = bus.load_width  ? bus.data_in : w_sh_q;
`ifdef PULSE_GEN16_PRESCALE_EN
        s_next = bus.load_prescale ? bus.data_in[7:0] : s_sh_q;
        step   = (pre_q == s_act_q);
`else
        step   = 1'b1;
`endif
        period_end = (state_q == RUN) && (ph_q == p_act_q - ONE) && step;
    end

    // Next-state logic. Priority is stop, then start, then wrap, then counting.
    always_comb begin
        state_d = state_q;
        p_sh_d  = p_next;
        w_sh_d  = w_next;
        p_act_d = p_act_q;
        w_act_d = w_act_q;
        ph_d    = ph_q;
        os_d    = os_q;
        reload  = 1'b0;
        halt    = 1'b0;
`ifdef PULSE_GEN16_PRESCALE_EN
        s_sh_d  = s_next;
        s_act_d = s_act_q;
        pre_d   = pre_q;
`endif
        if (bus.stop) begin
            halt = 1'b1;
        end else if (bus.start || period_end) begin
            // A one-shot run ends at its wrap. A zero period never starts.
            if (!bus.start && os_q) begin
                halt = 1'b1;
            end else if (p_next != '0) begin
                reload = 1'b1;
            end else begin
                halt = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (step) begin
                ph_d = ph_q + ONE;
            end
`ifdef PULSE_GEN16_PRESCALE_EN
            pre_d = step ? 8'd0 : pre_q + 8'd1;
`endif
        end

        if (reload) begin
            state_d = RUN;
            p_act_d = p_next;
            w_act_d = w_next;
            ph_d    = '0;
            if (bus.start) begin
                os_d = bus.oneshot;
            end
`ifdef PULSE_GEN16_PRESCALE_EN
            s_act_d = s_next;
            pre_d   = 8'd0;
`endif
        end
        if (halt) begin
            state_d = IDLE;
            ph_d    = '0;
`ifdef PULSE_GEN16_PRESCALE_EN
            pre_d   = 8'd0;
`endif
        end
    end

    // Register update. The synchronous active-low reset clears everything.
    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state_q <= IDLE;
            p_sh_q  <= '0;
            w_sh_q  <= '0;
            p_act_q <= '0;
            w_act_q <= '0;
            ph_q    <= '0;
            os_q    <= 1'b0;
`ifdef PULSE_GEN16_PRESCALE_EN
            s_sh_q  <= 8'd0;
            s_act_q <= 8'd0;
            pre_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            p_sh_q  <= p_sh_d;
            w_sh_q  <= w_sh_d;
            p_act_q <= p_act_d;
            w_act_q <= w_act_d;
            ph_q    <= ph_d;
            os_q    <= os_d;
`ifdef PULSE_GEN16_PRESCALE_EN
            s_sh_q  <= s_sh_d;
            s_act_q <= s_act_d;
            pre_q   <= pre_d;
`endif
        end
    end

    // Outputs are decoded from registers only, so pulse_out cannot glitch.
    assign bus.busy      = (state_q == RUN);
    assign bus.pulse_out = (state_q == RUN) && (ph_q < w_act_q);
    assign bus.tick      = period_end;
    assign bus.data_out  = (state_q == RUN) ? (p_act_q - ONE - ph_q) : '0;
endmodule

// File: tb/tb_pulse_gen16.sv
// tb_pulse_gen16: self-checking bench for pulse_gen16.
// A time-based reference model predicts the outputs. Each period is
// described by its start cycle and its length P*(S+1). Directed scenarios
// check the model's predictions, and a randomized run checks the model
// cycle by cycle.
module tb_pulse_gen16;
    logic sysclk = 1'b0;
    logic sysreset_n = 1'b0;

    pulse_gen16_if #(.WIDTH(16)) bus ();

    pulse_gen16 #(.WIDTH(16)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .bus        (bus)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    int cyc = 0;
    bit m_run = 0;
    int m_p = 0, m_w = 0, m_s = 0, m_os = 0;
    int m_psh = 0, m_wsh = 0, m_ssh = 0;
    int m_start = 0;

    // Expected {busy, pulse_out, tick, data_out} for the current cycle.
    function automatic logic [18:0] exp_out();
        int idx, ph;
        logic [15:0] d;
        if (!m_run) return 19'd0;
        idx = cyc - m_start;
        ph  = idx / (m_s + 1);
        d   = 16'(m_p - 1 - ph);
        return {1'b1, (ph < m_w), (idx == m_p * (m_s + 1) - 1), d};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.busy, bus.pulse_out, bus.tick, bus.data_out};
    endfunction

    // Advance one clock edge, update the model from the sampled inputs, and
    // return at the falling edge, ready to sample.
    task automatic clk_step();
        int np, nw, ns, len;
        bit ended;
        @(posedge sysclk);
        if (!sysreset_n) begin
            m_run = 0; m_p = 0; m_w = 0; m_s = 0; m_os = 0;
            m_psh = 0; m_wsh = 0; m_ssh = 0;
        end else begin
            np = bus.load_period ? int'(bus.data_in) : m_psh;
            nw = bus.load_width  ? int'(bus.data_in) : m_wsh;
            ns = m_ssh;
`ifdef PULSE_GEN16_PRESCALE_EN
            if (bus.load_prescale) ns = int'(bus.data_in[7:0]);
`endif
            len   = m_p * (m_s + 1);
            ended = m_run && (cyc - m_start == len - 1);
            if (bus.stop) begin
                m_run = 0;
            end else if (bus.start || ended) begin
                if ((!bus.start && m_os != 0) || np == 0) begin
                    m_run = 0;
                end else begin
                    m_run = 1; m_p = np; m_w = nw; m_s = ns;
                    if (bus.start) m_os = int'(bus.oneshot);
                    m_start = cyc + 1;
                end
            end
            m_psh = np; m_wsh = nw; m_ssh = ns;
        end
        cyc++;
        @(negedge sysclk);
    endtask

    task automatic drive(bit lp, bit lw, bit st, bit sp, bit os, int din);
        bus.load_period = lp;
        bus.load_width  = lw;
        bus.start       = st;
        bus.stop        = sp;
        bus.oneshot     = os;
        bus.data_in     = 16'(din);
`ifdef PULSE_GEN16_PRESCALE_EN
        bus.load_prescale = 1'b0;
`endif
    endtask

    task automatic load_pw(int p, int w);
        drive(1, 0, 0, 0, 0, p); clk_step();
        drive(0, 1, 0, 0, 0, w); clk_step();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        sysreset_n = 1'b0;
        drive(1, 1, 1, 0, 0, 5);
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++;
            if (obs() !== 19'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", i, obs());
            end
        end
        sysreset_n = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        clk_step();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== 19'd0 || obs() !== exp_out()) begin
            failures++;
            $display("FAIL reset_release got=%h want=0", obs());
        end
    endtask

    task automatic test_continuous();
        int k;
        load_pw(5, 2);
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            k = i % 5;
            checks++;
            if (bus.pulse_out !== (k < 2) || bus.tick !== (k == 4) || bus.busy !== 1'b1 ||
                bus.data_out !== 16'(4 - k)) begin
                failures++;
                $display("FAIL cont_pattern i=%0d got=%h want_pulse=%0d tick=%0d dout=%0d",
                         i, obs(), (k < 2), (k == 4), 4 - k);
            end
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL cont_model i=%0d got=%h want=%h", i, obs(), exp_out());
            end
            clk_step();
        end
        drive(0, 0, 0, 1, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== 19'd0) begin
            failures++;
            $display("FAIL cont_stop got=%h want=0", obs());
        end
    endtask

    task automatic test_oneshot();
        int nb = 0, np = 0, nt = 0;
        load_pw(4, 9);
        drive(0, 0, 1, 0, 1, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            nb += int'(bus.busy); np += int'(bus.pulse_out); nt += int'(bus.tick);
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL oneshot_model i=%0d got=%h want=%h", i, obs(), exp_out());
            end
            clk_step();
        end
        checks++;
        if (nb != 4 || np != 4 || nt != 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_counts busy=%0d pulse=%0d tick=%0d want 4 4 1", nb, np, nt);
        end
    endtask

    task automatic test_zero_period();
        int ticks[$];
        load_pw(0, 3);
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.pulse_out !== 1'b0) begin
                failures++;
                $display("FAIL zero_period i=%0d busy=%b pulse=%b want 0 0", i, bus.busy, bus.pulse_out);
            end
            clk_step();
        end
        load_pw(6, 2);
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (bus.tick === 1'b1) ticks.push_back(i);
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL shadow_model i=%0d got=%h want=%h", i, obs(), exp_out());
            end
            if (i == 2) drive(1, 0, 0, 0, 0, 3);
            else        drive(0, 0, 0, 0, 0, 0);
            clk_step();
        end
        checks++;
        if (ticks.size() != 4 || ticks[0] != 5 || ticks[1] != 8 || ticks[2] != 11 || ticks[3] != 14) begin
            failures++;
            $display("FAIL shadow_ticks n=%0d first=%0d want 4 ticks at 5,8,11,14",
                     ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
        end
        drive(0, 0, 0, 1, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_start_stop();
        int first_tick = -1;
        load_pw(5, 2);
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        clk_step(); clk_step();
        drive(0, 0, 1, 1, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== 19'd0) begin
            failures++;
            $display("FAIL start_and_stop got=%h want=0", obs());
        end
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        clk_step(); clk_step();
        checks++;
        if (bus.data_out !== 16'd2) begin
            failures++;
            $display("FAIL restart_pre dout=%0d want=2", bus.data_out);
        end
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.data_out !== 16'd4 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_post dout=%0d busy=%b want 4 1", bus.data_out, bus.busy);
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.tick === 1'b1 && first_tick < 0) first_tick = i;
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL restart_model i=%0d got=%h want=%h", i, obs(), exp_out());
            end
            clk_step();
        end
        checks++;
        if (first_tick != 4) begin
            failures++;
            $display("FAIL restart_tick at=%0d want=4", first_tick);
        end
        drive(0, 0, 0, 1, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
    endtask

`ifdef PULSE_GEN16_PRESCALE_EN
    task automatic test_prescale();
        int np = 0, nt = 0, tick_at = -1;
        drive(0, 0, 0, 0, 0, 2); bus.load_prescale = 1'b1; clk_step();
        drive(0, 0, 0, 0, 0, 0);
        load_pw(3, 1);
        drive(0, 0, 1, 0, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            np += int'(bus.pulse_out);
            if (bus.tick === 1'b1) begin nt++; tick_at = i; end
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL prescale_model i=%0d got=%h want=%h", i, obs(), exp_out());
            end
            clk_step();
        end
        checks++;
        if (np != 3 || nt != 1 || tick_at != 8) begin
            failures++;
            $display("FAIL prescale_counts pulse=%0d ticks=%0d at=%0d want 3 1 8", np, nt, tick_at);
        end
        drive(0, 0, 0, 1, 0, 0); clk_step(); drive(0, 0, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            sysreset_n = ($urandom_range(0, 299) != 0);
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 9)));
`ifdef PULSE_GEN16_PRESCALE_EN
            bus.load_prescale = ($urandom_range(0, 29) == 0);
`endif
            clk_step();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL random_model i=%0d got=%h want=%h", i, obs(), exp_out());
            end
        end
        sysreset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_continuous();
        test_oneshot();
        test_zero_period();
        test_start_stop();
`ifdef PULSE_GEN16_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_gen16.md
# pulse_gen16

Programmable 16-bit periodic pulse generator, the source-side counterpart of the countdown timer/counter peripheral. It produces a pulse train with a programmable period and high time on `pulse_out`, which can drive a timer's `counter_event` input directly. It supports continuous and one-shot modes. It sits on the same peripheral data bus as the timers and is loaded through strobed writes of `data_in`.

## Interface
- `WIDTH`, 16: width of the period, width and phase counters. All widths below are `WIDTH` unless stated otherwise.
- `sysclk` in 1: system clock. The block uses one clock and all logic is on its rising edge.
- `sysreset_n` in 1: synchronous, active-low reset.
- `data_in` in 16: write data for the load strobes.
- `load_period` in 1: writes `data_in` into the period shadow register `P_sh`.
- `load_width` in 1: writes `data_in` into the width shadow register `W_sh`.
- `start` in 1: begins or restarts the pulse train.
- `stop` in 1: halts the pulse train.
- `oneshot` in 1: sampled on start. 1 means a single period; 0 means continuous.
- `data_out` out 16: cycles remaining in the current period, `P_act-1-ph`. It reads 0 when idle.
- `pulse_out` out 1: the generated pulse.
- `busy` out 1: high while running.
- `tick` out 1: one-cycle strobe on the last cycle of each period.
- `load_prescale` in 1: present only with `PULSE_GEN16_PRESCALE_EN` (see Configuration).

## Operation
- Registers:
  - Shadow registers `P_sh` and `W_sh`.
  - Active registers `P_act` and `W_act`.
  - Phase counter `ph`.
  - Mode bit `os`.
  - State `IDLE` or `RUN`.
- Reset (`sysreset_n`=0 at a clock edge) clears every register to 0 and sets the state to `IDLE`. Every output then reads 0.
- `IDLE`:
  - `start`=1 with `P_sh`≠0: copy `P_sh`→`P_act`, `W_sh`→`W_act`, `oneshot`→`os`, set `ph`←0, go to `RUN`.
  - `start` with `P_sh`=0 is ignored and the block stays in `IDLE`.
- `RUN`:
  - `ph` increments each cycle.
  - When `ph`=`P_act`-1, `tick`=1 for that cycle.
  - At the next edge after that cycle: with `os`=1, go to `IDLE`. With `os`=0, set `ph`←0 and re-copy the shadows into `P_act`/`W_act`. A shadow value of 0 at that point stops the train and the block goes to `IDLE`.
- `pulse_out` = (`RUN`) && (`ph` < `W_act`). It is a function of registers only, so it is glitch-free.
  - `W_act`=0 keeps the output low.
  - `W_act` ≥ `P_act` keeps the output high for the whole run (100 % duty).
- `busy` = (state = `RUN`).
- Shadow loads never disturb a period in progress. They take effect only on start or on a continuous wrap.
- Priority at a single edge, highest first: reset, `stop`, `start`, normal counting.
  - `stop` forces `IDLE` and `ph`←0, including when `start` is asserted in the same cycle.
  - `start` while in `RUN` restarts the train: `ph`←0 and the shadows are reloaded.
  - `load_*` in the same cycle as `start` or a wrap: the new `data_in` value is the one copied into the active register. The shadow write is bypassed.
- Reset mid-run returns the block to `IDLE` at that edge with `pulse_out`=0. No `tick` is emitted.

## Timing
- Start latency: `start` is sampled at edge k. `busy` and `pulse_out` (if `W`>0) are high in the cycle after edge k.
- A period lasts exactly `P_act` sysclk cycles. `pulse_out` is high for the first min(`W_act`,`P_act`) cycles of it.
- Continuous mode: back-to-back periods with no gap cycle. `tick` occurs once every `P_act` cycles.
- One-shot mode: `busy` drops in the cycle after `tick`. The high time of `busy` is exactly `P_act` cycles.
- `stop` sampled at edge k: `pulse_out`, `busy` and `tick` are all 0 after edge k.
- `P`=1 with continuous mode: `tick` is high every cycle. With `W`≥1, `pulse_out` is constantly high.

## Configuration
- `PULSE_GEN16_PRESCALE_EN` defined:
  - Adds input `load_prescale`, which writes `data_in[7:0]` into an 8-bit prescale register `S`. `S` is reset to 0.
  - `ph` and `tick` advance only once every `S`+1 sysclk cycles.
  - `S` is sampled on start and on each wrap, like the shadow registers.
  - `tick` is asserted for the last sysclk cycle of the period only.
  - `S`=0 behaves identically to the macro being absent.
- Macro not defined: the `load_prescale` port and the `S` register do not exist, and `ph` advances every sysclk cycle.

## Test plan
- Reset, then hold `sysreset_n`=0 for 3 cycles while driving `start`=1 → all outputs stay 0 and `data_out`=0.
- `P`=5, `W`=2, continuous, start → `pulse_out` pattern 1,1,0,0,0 repeating. `tick` in cycles 5, 10, 15. `data_out` reads 4,3,2,1,0.
- `P`=4, `W`=9, one-shot → `pulse_out` and `busy` are each high for exactly 4 cycles. One `tick`. Then the block returns to `IDLE`.
- `P`=0, start → no `busy` and no `pulse_out`.
  - Then: with `P`=6 running, load `P`=3 mid-period → the current period completes at 6 cycles and the following periods are 3 cycles.
- `start` and `stop` together while running → `IDLE` after that edge.
  - Separately: `start` alone at `ph`=2 of a `P`=5 run → `ph` restarts at 0 and the next `tick` arrives 5 cycles later.
- With `PULSE_GEN16_PRESCALE_EN`: `S`=2, `P`=3, `W`=1 → `pulse_out` is high for 3 sysclk cycles and the period is 9 sysclk cycles, with a single-cycle `tick` in cycle 9.
